// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_W   = 64;  // widest packed BCD the helpers can describe (16 digits)

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Saturation pattern shown when the value does not fit in the available digits.
  function automatic logic [BCD_MAX_W-1:0] all_nines(input int digits);
    logic [BCD_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
);
  // start is sampled on every rising clk; it is accepted only while busy=0, and
  // bin is captured on that accept edge alone. done pulses for one cycle when
  // bcd/overflow change; both hold their value until the next done.
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock, with the
// committed result held stable between conversions.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus,
  output state_t            state_dbg
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2_f(BIN_WIDTH + 1);
  localparam logic [BCD_MAX_W-1:0] SAT_FULL = all_nines(DIGITS);
  localparam logic [BCD_W-1:0]     SAT      = SAT_FULL[BCD_W-1:0];

  state_t               state_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]     work_q;
  logic                 sticky_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 ovf_q;
  logic                 done_q;
  logic                 busy_q;

  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     work_next;
  logic [BIN_WIDTH-1:0] shift_next;
  logic                 sticky_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits and the binary remainder shift left as one long register.
  assign work_next   = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
  assign shift_next  = {shift_q[BIN_WIDTH-2:0], 1'b0};
  assign sticky_next = sticky_q | adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q  <= bus.bin;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CNT_W'(BIN_WIDTH);
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q  <= shift_next;
          work_q   <= work_next;
          sticky_q <= sticky_next;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= sticky_next ? SAT : work_next;
            ovf_q   <= sticky_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner values, randomized
// values, back-to-back conversions and asynchronous reset abort.
module tb_bin_to_bcd_seq;
  import bin_to_bcd_seq_pkg::*;

  localparam int BIN_WIDTH = 16;
  localparam int DIGITS    = 4;
  localparam int W         = 4*DIGITS + 1;  // {overflow, bcd}
  localparam int MAX_WAIT  = 40;

  logic   clk;
  logic   rst;
  state_t state_dbg;

  bin_to_bcd_seq_if #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division; anything past the digit range saturates.
  function automatic logic [W-1:0] model(input int unsigned v);
    logic [W-1:0] r;
    int unsigned limit;
    limit = 1;
    for (int d = 0; d < DIGITS; d++) limit = limit * 10;
    r = '0;
    if (v >= limit) begin
      r[W-1] = 1'b1;
      for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'd9;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        r[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string tag, output int lat, output int busy_n);
    logic [W-1:0] exp;
    bit seen;
    seen   = 0;
    lat    = -1;
    busy_n = 0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        lat  = i;
        exp  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_val({tag, "_result"}, {bus.overflow, bus.bcd}, exp);
      end else if (bus.busy) begin
        busy_n++;
      end
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic do_convert(input string tag, input logic [BIN_WIDTH-1:0] v);
    int lat, busy_n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.bin = BIN_WIDTH'($urandom);
    wait_done(tag, lat, busy_n);
    check_val({tag, "_latency"}, 64'(lat), 64'(BIN_WIDTH));
    check_val({tag, "_busy_cycles"}, 64'(busy_n), 64'(BIN_WIDTH));
    check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_val({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    check_val({tag, "_held"}, {bus.overflow, bus.bcd}, model(v));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_n, gap, dones;
    logic [BIN_WIDTH-1:0] seq_vals[4];
    logic [BIN_WIDTH-1:0] rv;
    seq_vals = '{16'h0063, 16'h03E7, 16'h0063, 16'h03E7};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_bcd", 64'(bus.bcd), 64'd0);
    check_val("rst_ovf", 64'(bus.overflow), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_state", 64'(state_dbg), 64'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed values, including both sides of the 9999/10000 boundary.
    do_convert("zero",  16'h0000);
    do_convert("v1234", 16'h04D2);
    do_convert("v9999", 16'h270F);
    do_convert("v10000",16'h2710);
    do_convert("vffff", 16'hFFFF);
    do_convert("v7",    16'h0007);

    // start during SHIFT is ignored and bin is not re-sampled.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'h0042;
    exp_q.push_back(model(16'h0042));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = '0;
    wait_done("ign", lat, busy_n);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_val("ign_extra_done", 64'(dones), 64'd0);
    check_val("ign_held", {bus.overflow, bus.bcd}, model(16'h0042));

    // start held high: back-to-back conversions, bin noise during SHIFT.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = seq_vals[0];
    exp_q.push_back(model(seq_vals[0]));
    for (int c = 0; c < 4; c++) begin
      logic [W-1:0] exp;
      bit seen;
      seen = 0;
      gap  = 0;
      for (int i = 0; i < MAX_WAIT && !seen; i++) begin
        @(negedge clk);
        gap++;
        if (bus.done) begin
          seen = 1;
          exp  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          check_val("b2b_result", {bus.overflow, bus.bcd}, exp);
          if (c < 3) begin
            bus.bin = seq_vals[c+1];
            exp_q.push_back(model(seq_vals[c+1]));
          end else begin
            bus.start = 1'b0;
          end
        end else begin
          bus.bin = BIN_WIDTH'($urandom);
        end
      end
      check_val("b2b_done_seen", 64'(seen), 64'd1);
      if (c > 0) check_val("b2b_period", 64'(gap), 64'(BIN_WIDTH + 1));
    end
    repeat (20) @(negedge clk);
    check_val("b2b_idle", 64'(bus.busy), 64'd0);

    // Randomized values across and below the saturation boundary.
    for (int n = 0; n < 20; n++) begin
      rv = (n % 2 == 0) ? BIN_WIDTH'($urandom_range(0, 9999))
                        : BIN_WIDTH'($urandom_range(0, 16'hFFFF));
      do_convert("rand", rv);
    end

    // Asynchronous reset mid-conversion aborts and clears the held result.
    do_convert("pre_rst", 16'h04D2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 16'h0999;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("arst_bcd", 64'(bus.bcd), 64'd0);
    check_val("arst_ovf", 64'(bus.overflow), 64'd0);
    check_val("arst_busy", 64'(bus.busy), 64'd0);
    check_val("arst_done", 64'(bus.done), 64'd0);
    check_val("arst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_val("arst_no_done", 64'(dones), 64'd0);
    check_val("arst_bcd_after", 64'(bus.bcd), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
